fc_layer: RTL and testbench
===========================

# fc_layer

Parametrised fully-connected layer engine for the MobileNet classifier head. It buffers one activation vector of IN_COUNT signed elements, then computes OUT_COUNT neurons. Each neuron is bias + Σ(activation × weight), evaluated LANES products per cycle, with optional ReLU. Sits after the global-average-pool stage and streams one ACC_WIDTH result per neuron to the output FIFO.

## Interface
- DATA_WIDTH, 8: signed activation/weight width.
- LANES, 4: elements per input/weight beat.
- ACC_WIDTH, 32: accumulator, bias and result width.
- IN_COUNT, 1024: vector length; must be a multiple of LANES.
- OUT_COUNT, 1000: neurons per run.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- relu_en  in  1  sampled at start; clamps negative results to 0.
- in_data  in  LANES*DATA_WIDTH  activation beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH], lower index = lower element.
- in_valid / in_ready  in / out  1  activation handshake.
- weight_data  in  LANES*DATA_WIDTH  weight beat, same lane order.
- weight_valid / weight_ready  in / out  1  weight handshake.
- bias_data  in  ACC_WIDTH  signed bias for current neuron.
- bias_valid / bias_ready  in / out  1  bias handshake.
- out_data  out  ACC_WIDTH  signed neuron result.
- out_valid / out_ready  out / in  1  result handshake.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last result transfers.

## Operation
- States: IDLE → LOAD_IN → LOAD_BIAS → MAC → EMIT → (LOAD_BIAS | FINISH) → IDLE.
- IDLE: all readies low. start=1 latches relu_en, clears counters, enters LOAD_IN. start is ignored in every other state.
- LOAD_IN: in_ready=1. Each accepted beat (valid&&ready) writes the activation buffer at beat index 0..IN_COUNT/LANES-1. After the last beat, go to LOAD_BIAS.
- LOAD_BIAS: bias_ready=1. On accept, acc ← bias_data; go to MAC.
- MAC: weight_ready=1. Each accepted beat i does acc ← acc + Σk sext(act[i][k]) × sext(w[i][k]). Products are 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH with no saturation. After beat IN_COUNT/LANES-1, go to EMIT.
- EMIT: out_valid=1 and out_data = (relu && acc<0) ? 0 : acc; both held stable until out_ready. On transfer, increment neuron counter. If it reaches OUT_COUNT, go to FINISH; else go to LOAD_BIAS.
- FINISH: done=1 for one cycle, then IDLE.
- Bias is added exactly once per neuron, never per lane or per beat.
- Activation buffer is reused for all OUT_COUNT neurons; it is not reloaded.
- Bubbles (valid low) on any input simply stall the state; no data is lost or duplicated.

## Timing
- Reset (reset_n=0, asynchronous): state IDLE. in_ready, weight_ready, bias_ready, out_valid, busy, done = 0. out_data = 0. Accumulator and counters = 0.
- Reset asserted mid-run aborts immediately. No done, no partial result. A later start begins a fresh run.
- Readies are registered-state decodes: they depend only on state, never combinationally on valid.
- Throughput: 1 beat/cycle in LOAD_IN and MAC.
- Minimum neuron latency: 1 (bias) + IN_COUNT/LANES (weights) + 1 (emit with out_ready=1) cycles.
- out_valid rises the cycle after the last weight beat is accepted.
- With out_ready held high, the next bias_ready rises the cycle after the emit transfer.
- done pulses the cycle after the final out transfer. busy falls in the same cycle that done falls.
- out_ready low holds EMIT indefinitely; weight_ready and bias_ready stay low meanwhile.

## Test plan
- Basic, LANES=4, IN_COUNT=8, OUT_COUNT=2, relu off:
  - stimulus: act 1..8; neuron0 weights all 1, bias 10; neuron1 weights all −1, bias 0.
  - required response: out 46 then −36; done one cycle after the second transfer.
- ReLU: same stimulus with relu_en=1 → outputs 46 then 0.
- Signed extremes: all act=−128, all w=−128, bias −5, IN_COUNT=8 → out 131067 (8×16384−5).
- Backpressure and bubbles:
  - stimulus: random in_valid/weight_valid/bias_valid gaps; out_ready low for 5 cycles during EMIT.
  - required response: results identical to the no-gap run; out_data stable while stalled.
- Wrap-around: ACC_WIDTH=16, bias 32767, one product of +1 → out −32768.
- Control: start pulsed mid-run is ignored. reset_n low during MAC clears all outputs at once with no done. A following run yields correct results.

Source files
------------

// File: rtl/fc_layer.sv
// Fully-connected layer engine: buffers one activation vector, then streams
// OUT_COUNT neuron results (bias + dot product, optional ReLU).
module fc_layer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int IN_COUNT   = 1024,
    parameter int OUT_COUNT  = 1000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          relu_en,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   weight_data,
    input  logic                          weight_valid,
    output logic                          weight_ready,
    input  logic [ACC_WIDTH-1:0]          bias_data,
    input  logic                          bias_valid,
    output logic                          bias_ready,
    output logic [ACC_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int BEATS = IN_COUNT / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NW    = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam logic [BW-1:0] LAST_BEAT   = BW'(BEATS - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(OUT_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IN,
        S_LOAD_BIAS,
        S_MAC,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LANES*DATA_WIDTH-1:0] r_act [BEATS];
    logic [BW-1:0]               r_beat;
    logic [NW-1:0]               r_neuron;
    logic [ACC_WIDTH-1:0]        r_acc;
    logic                        r_relu;

    logic [LANES*DATA_WIDTH-1:0] w_act_beat;
    logic signed [2*DATA_WIDTH-1:0] w_prod [LANES];
    logic signed [ACC_WIDTH-1:0] w_mac_sum;
    logic [ACC_WIDTH-1:0]        w_result;
    logic                        w_last_beat;

    assign w_act_beat  = r_act[r_beat];
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_result    = (r_relu && r_acc[ACC_WIDTH-1]) ? '0 : r_acc;

    // Each lane product is sign-extended to the accumulator width before summing.
    always_comb begin
        w_mac_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_prod[k] = $signed(w_act_beat[k*DATA_WIDTH +: DATA_WIDTH]) *
                        $signed(weight_data[k*DATA_WIDTH +: DATA_WIDTH]);
            w_mac_sum = w_mac_sum + ACC_WIDTH'(w_prod[k]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        in_ready     = 1'b0;
        bias_ready   = 1'b0;
        weight_ready = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        done         = 1'b0;
        busy         = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD_IN;
            end
            S_LOAD_IN: begin
                in_ready = 1'b1;
                if (in_valid && w_last_beat) w_next = S_LOAD_BIAS;
            end
            S_LOAD_BIAS: begin
                bias_ready = 1'b1;
                if (bias_valid) w_next = S_MAC;
            end
            S_MAC: begin
                weight_ready = 1'b1;
                if (weight_valid && w_last_beat) w_next = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = w_result;
                if (out_ready)
                    w_next = (r_neuron == LAST_NEURON) ? S_FINISH : S_LOAD_BIAS;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_relu   <= 1'b0;
            r_beat   <= '0;
            r_neuron <= '0;
            r_acc    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_relu   <= relu_en;
                        r_beat   <= '0;
                        r_neuron <= '0;
                        r_acc    <= '0;
                    end
                end
                S_LOAD_IN: begin
                    if (in_valid) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                end
                S_LOAD_BIAS: begin
                    if (bias_valid) r_acc <= bias_data;
                end
                S_MAC: begin
                    if (weight_valid) begin
                        r_acc  <= r_acc + w_mac_sum;
                        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) r_neuron <= r_neuron + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Activation buffer holds no reset; it is always fully rewritten before use.
    always_ff @(posedge clock) begin
        if (r_state == S_LOAD_IN && in_valid) r_act[r_beat] <= in_data;
    end

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: 32-bit and 16-bit accumulator instances share stimulus.
module tb_fc_layer;

    localparam int DW   = 8;
    localparam int LN   = 4;
    localparam int INC  = 8;
    localparam int OUTC = 2;
    localparam int NB   = INC / LN;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start, relu_en;
    logic [31:0] in_data, weight_data, bias_data;
    logic        in_valid, weight_valid, bias_valid, out_ready;
    logic        in_ready, weight_ready, bias_ready, out_valid, busy, done;
    logic [31:0] out_data;
    logic        in_ready16, weight_ready16, bias_ready16, out_valid16, busy16, done16;
    logic [15:0] out_data16;

    fc_layer #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(32), .IN_COUNT(INC), .OUT_COUNT(OUTC)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .relu_en(relu_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .weight_data(weight_data), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    fc_layer #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(16), .IN_COUNT(INC), .OUT_COUNT(OUTC)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start), .relu_en(relu_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready16),
        .weight_data(weight_data), .weight_valid(weight_valid), .weight_ready(weight_ready16),
        .bias_data(bias_data[15:0]), .bias_valid(bias_valid), .bias_ready(bias_ready16),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready),
        .busy(busy16), .done(done16)
    );

    int checks = 0;
    int failures = 0;
    logic signed [31:0] q_a[$];
    logic signed [15:0] q_b[$];

    int act[INC];
    int wt[OUTC][INC];
    int bias[OUTC];
    bit gaps = 0;
    int or_mode = 0;
    int xfer_in_run = 0;
    bit expect_done = 0;
    bit expect_idle = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer dot product, then wrap to the accumulator width.
    function automatic longint raw_sum(input int n);
        longint s = longint'(bias[n]);
        for (int j = 0; j < INC; j++) s += longint'(act[j]) * longint'(wt[n][j]);
        return s;
    endfunction

    function automatic logic signed [31:0] model_a(input int n, input bit relu);
        longint s = raw_sum(n);
        logic signed [31:0] r = s[31:0];
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic logic signed [15:0] model_b(input int n, input bit relu);
        longint s = raw_sum(n);
        logic signed [15:0] r = s[15:0];
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return in_ready;
            1:       return bias_ready;
            default: return weight_ready;
        endcase
    endfunction

    task automatic send(input int ch, input logic [31:0] d);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
        case (ch)
            0:       begin in_data = d;     in_valid = 1'b1;     end
            1:       begin bias_data = d;   bias_valid = 1'b1;   end
            default: begin weight_data = d; weight_valid = 1'b1; end
        endcase
        while (!rdy(ch) && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check("ready_timeout", 0, 1);
        @(negedge clock);
        in_valid = 1'b0; bias_valid = 1'b0; weight_valid = 1'b0;
        in_data = $urandom; weight_data = $urandom; bias_data = $urandom;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run(input bit relu, input bit mid_start, input bit abort);
        logic [31:0] d;
        int t;
        relu_en = relu;
        pulse_start();
        relu_en = ~relu;
        check("busy_after_start", busy, 1);
        for (int n = 0; n < OUTC; n++) begin
            q_a.push_back(model_a(n, relu));
            q_b.push_back(model_b(n, relu));
        end
        for (int b = 0; b < NB; b++) begin
            if (mid_start && b == 1) pulse_start();
            for (int k = 0; k < LN; k++) d[k*DW +: DW] = 8'(act[b*LN + k]);
            send(0, d);
        end
        for (int n = 0; n < OUTC; n++) begin
            if (mid_start && n == 1) pulse_start();
            send(1, 32'(bias[n]));
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < LN; k++) d[k*DW +: DW] = 8'(wt[n][b*LN + k]);
                send(2, d);
                if (abort && b == 0) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_in_ready", in_ready, 0);
                    check("abort_w_ready", weight_ready, 0);
                    check("abort_b_ready", bias_ready, 0);
                    check("abort_out_valid", out_valid, 0);
                    check("abort_out_data", out_data, 0);
                    check("abort_busy", busy, 0);
                    check("abort_done", done, 0);
                    q_a.delete(); q_b.delete();
                    xfer_in_run = 0; expect_done = 0; expect_idle = 0;
                    @(negedge clock);
                    reset_n = 1'b1;
                    @(negedge clock);
                    return;
                end
            end
            check("out_valid_after_last_weight", out_valid, 1);
        end
        t = 0;
        while ((busy || q_a.size() != 0) && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) check("run_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic randomize_data();
        for (int j = 0; j < INC; j++) act[j] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < OUTC; n++) begin
            bias[n] = int'($urandom);
            for (int j = 0; j < INC; j++) wt[n][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // out_ready driver: in mode 1 every result is first stalled for 5 cycles.
    int stall_cnt = 0;
    bit stalled = 0;
    always @(posedge clock) begin
        #1;
        if (or_mode == 0) out_ready = 1'b1;
        else if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
        else if (out_valid && !stalled) begin stalled = 1; stall_cnt = 4; out_ready = 1'b0; end
        else begin
            out_ready = 1'($urandom_range(0, 1));
            if (!out_valid) stalled = 0;
        end
    end

    // Monitor: pops the scoreboard on each result transfer and watches done/busy.
    bit prev_stall = 0;
    logic [31:0] prev_data;
    always @(negedge clock) begin
        if (!reset_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (expect_done) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 1);
                expect_done = 0;
                expect_idle = 1;
            end else if (expect_idle) begin
                check("done_fall", done, 0);
                check("busy_fall", busy, 0);
                expect_idle = 0;
            end else if (done) check("spurious_done", done, 0);
            if (out_valid) begin
                check("readies_low_in_emit", {in_ready, weight_ready, bias_ready}, 0);
                check("out_valid16", out_valid16, 1);
            end
            if (out_valid && out_ready) begin
                if (q_a.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    check("out_data", $signed(out_data), q_a.pop_front());
                    check("out_data16", $signed(out_data16), q_b.pop_front());
                    xfer_in_run++;
                    if (xfer_in_run == OUTC) begin
                        xfer_in_run = 0;
                        expect_done = 1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; relu_en = 1'b0;
        in_data = '0; weight_data = '0; bias_data = '0;
        in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_w_ready", weight_ready, 0);
        check("rst_b_ready", bias_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed: act 1..8, neuron0 weights +1 bias 10, neuron1 weights -1 bias 0.
        for (int j = 0; j < INC; j++) begin
            act[j] = j + 1; wt[0][j] = 1; wt[1][j] = -1;
        end
        bias[0] = 10; bias[1] = 0;
        run(0, 0, 0);
        run(1, 0, 0);

        for (int j = 0; j < INC; j++) begin
            act[j] = -128; wt[0][j] = -128; wt[1][j] = -128;
        end
        bias[0] = -5; bias[1] = -5;
        run(0, 0, 0);

        for (int j = 0; j < INC; j++) begin
            act[j] = 0; wt[0][j] = 0; wt[1][j] = 0;
        end
        act[0] = 1; wt[0][0] = 1; wt[1][0] = 1;
        bias[0] = 32767; bias[1] = 32767;
        run(0, 0, 0);

        randomize_data();
        run(0, 1, 0);

        gaps = 1; or_mode = 1;
        for (int j = 0; j < INC; j++) begin
            act[j] = j + 1; wt[0][j] = 1; wt[1][j] = -1;
        end
        bias[0] = 10; bias[1] = 0;
        run(0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            randomize_data();
            run(1'($urandom_range(0, 1)), 0, 0);
        end

        gaps = 0; or_mode = 0;
        randomize_data();
        run(0, 0, 1);
        run(1, 0, 0);
        randomize_data();
        run(0, 0, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", q_a.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
